fanin_rr_collector: RTL and testbench
=====================================

Name: fanin_rr_collector

Overview:
- Upward fan-in counterpart to the five-way structural fan-out used throughout the module tree.
- Merges NUM_CH child result streams into one parent stream using round-robin arbitration.
- Registered single-entry output stage; each output beat is tagged with its source channel index.
- Sits at each hierarchy node between the child instances and the parent.

Parameters:
- DATA_W, 8, payload width per channel.
- NUM_CH, 5, number of child channels; legal range 2..8.
- SRC_W, 3, width of the source tag; must be >= clog2(NUM_CH).
- CNT_W, 16, width of the delivered-beat counter.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  NUM_CH  per-channel valid; bit i belongs to channel i.
- in_data  in  NUM_CH*DATA_W  channel i payload at bits [i*DATA_W +: DATA_W].
- in_ready  out  NUM_CH  per-channel ready; one-hot or zero.
- out_valid  out  1  output holding register occupied.
- out_data  out  DATA_W  held payload.
- out_src  out  SRC_W  channel index of the held payload.
- out_ready  in  1  parent accepts the beat.
- beat_cnt  out  CNT_W  number of completed output handshakes; saturating.
- busy  out  1  out_valid OR any in_valid.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - out_valid=0, out_data=0, out_src=0, beat_cnt=0.
  - Round-robin pointer last=NUM_CH-1, so channel 0 has first priority.
  - Any held beat is discarded; reset mid-transfer loses it, no replay.
- Slot free: free = !out_valid || out_ready. Combinational; the output register can be drained and refilled in the same cycle.
- Arbitration (combinational, every cycle):
  - Search channels last+1, last+2, ... with wrap NUM_CH-1 -> 0.
  - The first i with in_valid[i]=1 is the grant g.
  - in_ready[g] = free; all other in_ready bits are 0.
  - If no request, in_ready = 0.
- in_ready depends combinationally on in_valid and out_ready. Upstream must not derive in_valid from in_ready.
- Input handshake (in_valid[g] && in_ready[g]) at the edge:
  - out_data <= payload g; out_src <= g; out_valid <= 1; last <= g.
- Output handshake without a refill: out_valid <= 0; out_data and out_src keep their values.
- Latency: input handshake to out_valid is 1 cycle. Sustained throughput is 1 beat/cycle while out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0:
  - in_ready = 0; held data is stable; last is frozen.
- beat_cnt:
  - Increments on every out_valid && out_ready.
  - Holds at 2^CNT_W-1 once reached; no wrap.
- Fairness: with all channels requesting continuously, grants are 0,1,...,NUM_CH-1,0,... Each channel is served at most NUM_CH beats after it asserts valid, given out_ready=1.
- Protocol rules (bench checks; the RTL relies on neither):
  - A channel holds in_data stable and in_valid high until its handshake.
  - The parent holds out_ready independently of out_valid.
- A request arriving in the same cycle as an unrelated channel's grant is not lost. It is served on a later cycle per pointer order.

Test Plan:
- Reset, then in_valid=5'b00100, data[2]=8'hA5, out_ready=1 -> in_ready=5'b00100 same cycle; next cycle out_valid=1, out_data=A5, out_src=2; beat_cnt=1 one cycle later.
- All five channels valid continuously, data[i]=8'h10+i, out_ready=1 -> out_src sequence 0,1,2,3,4,0,1 on consecutive cycles with no bubbles; beat_cnt=7 after 7 beats.
- Hold a beat with out_ready=0 for 4 cycles while channels 1 and 3 request -> in_ready=0 throughout; out_data and out_src unchanged; after out_ready=1, channel 1 then channel 3 delivered.
- Only channel 4 valid, after last=4 -> channel 4 re-granted via wrap (pointer 4 -> 0..3 empty -> 4); back-to-back beats at 1/cycle.
- Assert rst_n=0 while out_valid=1 and out_ready=0 -> out_valid=0 immediately (async); beat_cnt=0; after release, first grant goes to lowest-index requester.
- CNT_W=4, 20 beats delivered -> beat_cnt reaches 15 and stays at 15.

Source files
------------

// File: rtl/fanin_rr_collector_if.sv
// Handshake bundle between child result streams, the fan-in collector and its parent.
// Carries the per-channel request side, the registered output side and status.
interface fanin_rr_collector_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CH = 5,
    parameter int unsigned SRC_W  = 3,
    parameter int unsigned CNT_W  = 16
);
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [SRC_W-1:0]         out_src;
    logic                     out_ready;
    logic [CNT_W-1:0]         beat_cnt;
    logic                     busy;

    // Environment side: drives children and parent ready.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src, beat_cnt, busy
    );

    // Collector side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src, beat_cnt, busy
    );
endinterface

// File: rtl/fanin_rr_collector.sv
// Round-robin fan-in of NUM_CH child streams into one registered, source-tagged parent stream.
// Also counts delivered beats (saturating) and reports activity.
module fanin_rr_collector #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CH = 5,
    parameter int unsigned SRC_W  = 3,
    parameter int unsigned CNT_W  = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    fanin_rr_collector_if.slave bus
);
    localparam logic [SRC_W-1:0] LastRst = SRC_W'(NUM_CH - 1);
    localparam logic [SRC_W:0]   NumChW  = (SRC_W + 1)'(NUM_CH);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [SRC_W-1:0]  out_src_q, out_src_d;
    logic [SRC_W-1:0]  last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [DATA_W-1:0] payload [NUM_CH];
    logic              grant_vld;
    logic [SRC_W-1:0]  grant_idx;
    logic [SRC_W:0]    cand_sum;
    logic [SRC_W-1:0]  cand;
    logic              free;
    logic              take;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign payload[i] = bus.in_data[i*DATA_W +: DATA_W];
    end

    // Walk channels starting just after the last grant, wrapping at NUM_CH.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            cand_sum = {1'b0, last_q} + (SRC_W + 1)'(k);
            if (cand_sum >= NumChW) begin
                cand_sum = cand_sum - NumChW;
            end
            cand = cand_sum[SRC_W-1:0];
            if (!grant_vld && bus.in_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign free = !out_valid_q || bus.out_ready;
    assign take = grant_vld && free;

    always_comb begin
        bus.in_ready = '0;
        if (take) begin
            bus.in_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        if (take) begin
            out_valid_d = 1'b1;
            out_data_d  = payload[grant_idx];
            out_src_d   = grant_idx;
            last_d      = grant_idx;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (out_valid_q && bus.out_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            last_q      <= LastRst;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.beat_cnt  = cnt_q;
    assign bus.busy      = out_valid_q || (bus.in_valid != '0);
endmodule

// File: tb/tb_fanin_rr_collector.sv
// Randomised and directed bench for fanin_rr_collector with a queue-based scoreboard.
// A second instance with a 4-bit counter shares the stimulus to exercise saturation.
module tb_fanin_rr_collector;
    localparam int N  = 5;
    localparam int DW = 8;

    typedef struct packed {
        logic [2:0]    src;
        logic [DW-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fanin_rr_collector_if #(.DATA_W(DW), .NUM_CH(N), .SRC_W(3), .CNT_W(16)) bus ();
    fanin_rr_collector_if #(.DATA_W(DW), .NUM_CH(N), .SRC_W(3), .CNT_W(4))  bus4 ();

    fanin_rr_collector #(.DATA_W(DW), .NUM_CH(N), .SRC_W(3), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    fanin_rr_collector #(.DATA_W(DW), .NUM_CH(N), .SRC_W(3), .CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    logic [N-1:0]    vld;
    logic [DW-1:0]   dat [N];
    logic            ordy;
    logic [N*DW-1:0] dat_flat;

    always_comb begin
        dat_flat = '0;
        for (int i = 0; i < N; i++) dat_flat[i*DW +: DW] = dat[i];
    end

    assign bus.in_valid   = vld;
    assign bus.in_data    = dat_flat;
    assign bus.out_ready  = ordy;
    assign bus4.in_valid  = vld;
    assign bus4.in_data   = dat_flat;
    assign bus4.out_ready = ordy;

    int          checks = 0;
    int          failures = 0;
    beat_t       exp_q[$];
    int unsigned obs_q[$];
    int unsigned mon_beats = 0;
    int          m_last = N - 1;
    bit          m_ov = 1'b0;
    logic [N-1:0] refill = '0;
    bit          rand_mode = 1'b0;
    bit          fixed_data = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the presented beat with the scoreboard head every cycle.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            mon_beats = 0;
        end else begin
            chk("beat_cnt", bus.beat_cnt, mon_beats);
            chk("beat_cnt_sat4", bus4.beat_cnt, (mon_beats > 15) ? 15 : mon_beats);
            chk("out_valid", bus.out_valid, exp_q.size() != 0);
            chk("out_valid4", bus4.out_valid, exp_q.size() != 0);
            if (bus.out_valid && exp_q.size() != 0) begin
                chk("out_src", bus.out_src, exp_q[0].src);
                chk("out_data", bus.out_data, exp_q[0].data);
                chk("out_src4", bus4.out_src, exp_q[0].src);
                if (ordy) begin
                    obs_q.push_back(bus.out_src);
                    void'(exp_q.pop_front());
                    mon_beats++;
                end
            end
        end
    end

    // One cycle: reference arbitration from the rules, then advance the children.
    task automatic step();
        int         g;
        int         hs;
        bit         free;
        logic [N-1:0] er;
        beat_t      b;
        @(negedge clk);
        #1;
        hs = -1;
        if (rst_n) begin
            free = !m_ov || ordy;
            g = -1;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (g < 0 && vld[c]) g = c;
            end
            er = '0;
            if (g >= 0 && free) er[g] = 1'b1;
            chk("in_ready", bus.in_ready, er);
            chk("busy", bus.busy, m_ov || (vld != 0));
            if (g >= 0 && free) begin
                b.src = 3'(g);
                b.data = dat[g];
                exp_q.push_back(b);
                m_last = g;
                m_ov = 1'b1;
                hs = g;
            end else if (m_ov && ordy) begin
                m_ov = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        if (hs >= 0) begin
            vld[hs] = 1'b0;
            if (refill[hs]) begin
                vld[hs] = 1'b1;
                dat[hs] = fixed_data ? 8'(16 + hs) : 8'($urandom);
            end
        end
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if (!vld[i] && $urandom_range(1, 0) == 1) begin
                    vld[i] = 1'b1;
                    dat[i] = 8'($urandom);
                end
            end
            ordy = ($urandom_range(3, 0) != 0);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        obs_q.delete();
        m_last = N - 1;
        m_ov = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        vld = '0;
        ordy = 1'b0;
        refill = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vld = '0;
        ordy = 1'b0;
        for (int i = 0; i < N; i++) dat[i] = '0;
        do_reset();

        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_src", bus.out_src, 0);
        chk("rst_beat_cnt", bus.beat_cnt, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_busy", bus.busy, 0);

        // Single request on channel 2.
        vld = 5'b00100;
        dat[2] = 8'hA5;
        ordy = 1'b1;
        #1;
        chk("single_in_ready", bus.in_ready, 5'b00100);
        step();
        chk("single_out_valid", bus.out_valid, 1);
        chk("single_out_data", bus.out_data, 8'hA5);
        chk("single_out_src", bus.out_src, 2);
        step();
        chk("single_beat_cnt", bus.beat_cnt, 1);

        // All channels requesting continuously.
        do_reset();
        fixed_data = 1'b1;
        for (int i = 0; i < N; i++) dat[i] = 8'(16 + i);
        vld = '1;
        refill = '1;
        ordy = 1'b1;
        repeat (7) step();
        refill = '0;
        vld = '0;
        repeat (3) step();
        fixed_data = 1'b0;
        chk("rr_beat_cnt", bus.beat_cnt, 7);
        chk("rr_obs_count", obs_q.size(), 7);
        for (int i = 0; i < 7 && i < obs_q.size(); i++) chk("rr_order", obs_q[i], i % N);

        // Backpressure holds the beat and blocks all channels.
        do_reset();
        vld = 5'b00001;
        dat[0] = 8'h55;
        step();
        vld = 5'b01010;
        dat[1] = 8'h31;
        dat[3] = 8'h33;
        repeat (4) step();
        chk("bp_hold_data", bus.out_data, 8'h55);
        chk("bp_hold_src", bus.out_src, 0);
        ordy = 1'b1;
        repeat (4) step();
        chk("bp_obs_count", obs_q.size(), 3);
        if (obs_q.size() == 3) begin
            chk("bp_order0", obs_q[0], 0);
            chk("bp_order1", obs_q[1], 1);
            chk("bp_order2", obs_q[2], 3);
        end

        // Lone channel 4 re-granted through the wrap, one beat per cycle.
        obs_q.delete();
        vld = 5'b10000;
        dat[4] = 8'h44;
        refill = 5'b10000;
        repeat (4) step();
        refill = '0;
        vld = '0;
        repeat (2) step();
        chk("wrap_obs_count", obs_q.size(), 4);
        for (int i = 0; i < obs_q.size(); i++) chk("wrap_src", obs_q[i], 4);

        // Async reset while a beat is held under backpressure.
        ordy = 1'b0;
        vld = 5'b00100;
        dat[2] = 8'h77;
        step();
        chk("pre_rst_out_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", bus.out_valid, 0);
        chk("async_beat_cnt", bus.beat_cnt, 0);
        chk("async_out_valid4", bus4.out_valid, 0);
        model_clear();
        vld = 5'b01010;
        dat[1] = 8'h11;
        dat[3] = 8'h13;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ordy = 1'b1;
        repeat (3) step();
        chk("post_rst_obs_count", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            chk("post_rst_first", obs_q[0], 1);
            chk("post_rst_second", obs_q[1], 3);
        end

        // Randomised traffic with random backpressure.
        do_reset();
        rand_mode = 1'b1;
        ordy = 1'b1;
        repeat (400) step();
        rand_mode = 1'b0;
        ordy = 1'b1;
        for (int i = 0; i < 100 && (vld != 0 || exp_q.size() != 0); i++) step();
        repeat (2) step();
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("drain_inputs_idle", vld, 0);
        chk("cnt4_saturated", bus4.beat_cnt, 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
